// File: rtl/cla_pkg.sv
// cla_arbiter shared definitions: default width, sum type, id sizing.
// Imported by the shared adder and the arbiter top.
package cla_pkg;

  localparam int WIDTH = 32;

  typedef logic [WIDTH:0] sum_t;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla_arbiter_cla.sv
// Carry-lookahead adder: 4-bit groups with group generate/propagate
// driving the inter-group carry chain.
module cla
  import cla_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   z
);

  localparam int BLK = 4;

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] c;
  logic         cin;
  logic         cy;
  logic         gg;
  logic         pp;

  always_comb begin
    g   = a & b;
    p   = a ^ b;
    c   = '0;
    cin = 1'b0;
    cy  = 1'b0;
    gg  = 1'b0;
    pp  = 1'b1;
    for (int base = 0; base < W; base += BLK) begin
      cy = cin;
      gg = 1'b0;
      pp = 1'b1;
      for (int k = 0; k < BLK; k++) begin
        if (base + k < W) begin
          c[base+k] = cy;
          cy = g[base+k] | (p[base+k] & cy);
          gg = g[base+k] | (p[base+k] & gg);
          pp = pp & p[base+k];
        end
      end
      // group carry-out skips the in-group ripple
      cin = gg | (pp & cin);
    end
    z = {cin, p ^ c};
  end

endmodule

// File: rtl/cla_arbiter.sv
// Round-robin arbiter feeding one shared adder through a two-stage
// valid/ready pipeline (S1 operands, S2 registered sum).
module cla_arbiter
  import cla_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = cla_pkg::WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_valid,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic [N_REQ-1:0][WIDTH-1:0]       req_a,
  input  logic [N_REQ-1:0][WIDTH-1:0]       req_b,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [WIDTH:0]                    rsp_sum,
  output logic [id_w(N_REQ)-1:0]            rsp_id,
  output logic [15:0]                       op_count
);

  localparam int IDW = id_w(N_REQ);
  typedef logic [IDW-1:0] id_t;

  id_t              ptr_q, ptr_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  id_t              s1_id_q, s1_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH:0]   rsp_sum_q, rsp_sum_d;
  id_t              rsp_id_q, rsp_id_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             s1_ready;
  logic             s2_ready;
  logic             found;
  logic             grant;
  id_t              gnt_idx;
  id_t              cand;
  logic [WIDTH:0]   z;

  cla #(.W(WIDTH)) u_cla (
    .a (s1_a_q),
    .b (s1_b_q),
    .z (z)
  );

  assign s2_ready = !rsp_valid_q || rsp_ready;
  assign s1_ready = !s1_valid_q || s2_ready;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = id_t'((int'(ptr_q) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign grant = !rst && s1_ready && found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    cnt_d       = cnt_q + {15'd0, rsp_valid_q && rsp_ready};
    if (s2_ready) begin
      s1_valid_d  = 1'b0;
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_sum_d = z;
        rsp_id_d  = s1_id_q;
      end
    end
    // refill S1 on the same edge it drains
    if (grant) begin
      s1_valid_d = 1'b1;
      s1_a_d     = req_a[gnt_idx];
      s1_b_d     = req_b[gnt_idx];
      s1_id_d    = gnt_idx;
      ptr_d      = (gnt_idx == id_t'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_cla_arbiter.sv
// Bench for cla_arbiter: directed scenarios plus a randomized run
// scored against a round-robin/FIFO reference model.
module tb_cla_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0][W-1:0]   req_a;
  logic [N-1:0][W-1:0]   req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [W:0]            rsp_sum;
  logic [1:0]            rsp_id;
  logic [15:0]           op_count;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] s_rdy;
  logic [N-1:0] s_hs;
  logic         s_rv;
  logic         s_rsp;
  logic [W:0]   s_sum;
  logic [1:0]   s_id;

  cla_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] add(input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++)
      if (oh[i]) return i;
    return -1;
  endfunction

  // sample just before the edge, then advance one clock
  task automatic tick();
    #3;
    s_rdy = req_ready;
    s_hs  = req_ready & req_valid;
    s_rv  = rsp_valid;
    s_rsp = rsp_valid && rsp_ready;
    s_sum = rsp_sum;
    s_id  = rsp_id;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    tick();
    tick();
    total++;
    if (s_rdy !== '0) begin
      bad++;
      $display("FAIL reset_ready got=%b want=0000", s_rdy);
    end
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid);
    end
    total++;
    if (op_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_op_count got=%0d want=0", op_count);
    end
    rst       = 1'b0;
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    req_a[2]  = 32'd5;
    req_b[2]  = 32'd7;
    rsp_ready = 1'b1;
    tick();
    total++;
    if (s_hs !== 4'b0100) begin
      bad++;
      $display("FAIL single_grant got=%b want=0100", s_hs);
    end
    req_valid = '0;
    tick();
    total++;
    if (s_rv !== 1'b0) begin
      bad++;
      $display("FAIL single_early got=%b want=0", s_rv);
    end
    tick();
    total++;
    if (s_rv !== 1'b1 || s_sum !== 33'd12 || s_id !== 2'd2) begin
      bad++;
      $display("FAIL single_rsp got=%b/%0d/%0d want=1/12/2",
               s_rv, s_sum, s_id);
    end
    total++;
    if (op_count !== 16'd1) begin
      bad++;
      $display("FAIL single_count got=%0d want=1", op_count);
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic [W:0]   te [3];
    ta = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    tb = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0};
    te = '{33'h1_0000_0000, 33'h1_FFFF_FFFE, 33'h0};
    rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      req_valid = 4'b0001;
      req_a[0]  = ta[t];
      req_b[0]  = tb[t];
      tick();
      req_valid = '0;
      tick();
      tick();
      total++;
      if (s_rsp !== 1'b1 || s_sum !== te[t] || s_id !== 2'd0) begin
        bad++;
        $display("FAIL carry_%0d got=%b/%h/%0d want=1/%h/0",
                 t, s_rsp, s_sum, s_id, te[t]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_hs;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i] = 32'(i * 100 + 1);
      req_b[i] = 32'(i + 7);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? '1 : '0;
      tick();
      if (c < 8) begin
        exp_hs = '0;
        exp_hs[c % N] = 1'b1;
        total++;
        if (s_hs !== exp_hs) begin
          bad++;
          $display("FAIL rr_grant c=%0d got=%b want=%b", c, s_hs, exp_hs);
        end
      end
      if (c >= 2 && c <= 9) begin
        total++;
        if (s_rsp !== 1'b1 || int'(s_id) != (c - 2) % N ||
            s_sum !== add(req_a[(c-2)%N], req_b[(c-2)%N])) begin
          bad++;
          $display("FAIL rr_rsp c=%0d got=%b/%0d/%0d want=1/%0d",
                   c, s_rsp, s_id, s_sum, (c - 2) % N);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int         ngr;
    int         got;
    logic [W:0] held;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i] = $urandom;
      req_b[i] = $urandom;
    end
    rsp_ready = 1'b0;
    req_valid = 4'b0111;
    ngr  = 0;
    held = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (s_hs != '0) ngr++;
      req_valid = req_valid & ~s_hs;
      if (c == 2) held = s_sum;
      if (c >= 3) begin
        total++;
        if (s_rv !== 1'b1 || s_sum !== held) begin
          bad++;
          $display("FAIL bp_stable c=%0d got=%b/%h want=1/%h",
                   c, s_rv, s_sum, held);
        end
      end
    end
    total++;
    if (ngr != 2) begin
      bad++;
      $display("FAIL bp_accepted got=%0d want=2", ngr);
    end
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      tick();
      req_valid = req_valid & ~s_hs;
      if (s_rsp) begin
        total++;
        if (int'(s_id) != got || s_sum !== add(req_a[got], req_b[got])) begin
          bad++;
          $display("FAIL bp_order got=%0d/%h want=%0d/%h", s_id, s_sum,
                   got, add(req_a[got], req_b[got]));
        end
        got++;
      end
    end
    total++;
    if (got != 3) begin
      bad++;
      $display("FAIL bp_drain got=%0d want=3", got);
    end
  endtask

  task automatic test_reset_midflight();
    int nrsp;
    do_reset();
    req_valid = '1;
    rsp_ready = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    total++;
    if (s_rdy !== '0) begin
      bad++;
      $display("FAIL mid_rst_ready got=%b want=0000", s_rdy);
    end
    rst       = 1'b0;
    req_valid = 4'b0110;
    rsp_ready = 1'b1;
    total++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd0) begin
      bad++;
      $display("FAIL mid_clear got=%b/%0d want=0/0", rsp_valid, op_count);
    end
    tick();
    total++;
    if (s_hs !== 4'b0010) begin
      bad++;
      $display("FAIL mid_first_grant got=%b want=0010", s_hs);
    end
    req_valid = '0;
    nrsp = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (s_rsp) begin
        nrsp++;
        total++;
        if (s_id !== 2'd1) begin
          bad++;
          $display("FAIL mid_stale got=%0d want=1", s_id);
        end
      end
    end
    total++;
    if (nrsp != 1) begin
      bad++;
      $display("FAIL mid_rsp_count got=%0d want=1", nrsp);
    end
  endtask

  task automatic test_random();
    logic [W:0] qs[$];
    int         qi[$];
    int         mptr;
    int         pick;
    int         ncnt;
    logic       stall;
    logic [W:0] psum;
    logic [1:0] pid;
    logic [W:0] es;
    int         ei;
    do_reset();
    mptr  = 0;
    ncnt  = 0;
    stall = 1'b0;
    psum  = '0;
    pid   = '0;
    for (int c = 0; c < 20010; c++) begin
      if (c < 20000) begin
        req_valid = N'($urandom);
        for (int i = 0; i < N; i++) begin
          req_a[i] = $urandom;
          req_b[i] = $urandom;
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        req_valid = '0;
        rsp_ready = 1'b1;
      end
      tick();
      total++;
      if (s_rdy !== s_hs || !$onehot0(s_hs)) begin
        bad++;
        $display("FAIL rnd_ready c=%0d rdy=%b valid=%b", c, s_rdy, req_valid);
      end
      if (s_hs != '0) begin
        pick = rr_pick(mptr, req_valid);
        total++;
        if (idx_of(s_hs) != pick) begin
          bad++;
          $display("FAIL rnd_rr c=%0d got=%0d want=%0d", c, idx_of(s_hs), pick);
        end
        qs.push_back(add(req_a[idx_of(s_hs)], req_b[idx_of(s_hs)]));
        qi.push_back(idx_of(s_hs));
        mptr = (idx_of(s_hs) + 1) % N;
      end
      if (stall) begin
        total++;
        if (s_rv !== 1'b1 || s_sum !== psum || s_id !== pid) begin
          bad++;
          $display("FAIL rnd_hold c=%0d got=%b/%h/%0d want=1/%h/%0d",
                   c, s_rv, s_sum, s_id, psum, pid);
        end
      end
      stall = s_rv && !s_rsp;
      psum  = s_sum;
      pid   = s_id;
      if (s_rsp) begin
        ncnt++;
        total++;
        if (qs.size() == 0) begin
          bad++;
          $display("FAIL rnd_extra c=%0d id=%0d sum=%h", c, s_id, s_sum);
        end else begin
          es = qs.pop_front();
          ei = qi.pop_front();
          if (s_sum !== es || int'(s_id) != ei) begin
            bad++;
            $display("FAIL rnd_rsp c=%0d got=%0d/%h want=%0d/%h",
                     c, s_id, s_sum, ei, es);
          end
        end
      end
    end
    total++;
    if (qs.size() != 0) begin
      bad++;
      $display("FAIL rnd_lost pending=%0d", qs.size());
    end
    total++;
    if (op_count !== 16'(ncnt)) begin
      bad++;
      $display("FAIL rnd_count got=%0d want=%0d", op_count, 16'(ncnt));
    end
    total++;
    if (ncnt < 5000) begin
      bad++;
      $display("FAIL rnd_throughput got=%0d want>=5000", ncnt);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
